// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin signal controller for an N-approach intersection.
// Each approach is served GREEN -> AMBER -> ALL_RED in turn, with latched pedestrian
// requests (walk plus extended green) and a flashing-amber maintenance mode.
// All phase timing advances only on the one-clk-wide tick strobe.
module traffic_phase_ctrl #(
    parameter int N_APP    = 4,
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 25,
    parameter int T_AMBER  = 5,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 10,
    localparam int AW      = (N_APP > 1) ? $clog2(N_APP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [N_APP-1:0] ped_req,
    input  logic             flash_mode,
    output logic [N_APP-1:0] red_o,
    output logic [N_APP-1:0] amber_o,
    output logic [N_APP-1:0] green_o,
    output logic [N_APP-1:0] walk_o,
    output logic [AW-1:0]    cur_app,
    output logic [CNT_W-1:0] remain
);

    typedef enum logic [1:0] {
        S_ALL_RED,
        S_GREEN,
        S_AMBER,
        S_FLASH
    } state_e;

    // Counter reload values: a phase of T ticks starts at T-1 and ends on the tick at 0.
    localparam logic [CNT_W-1:0] R_GREEN     = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] R_GREEN_PED = CNT_W'(T_GREEN + T_PED - 1);
    localparam logic [CNT_W-1:0] R_AMBER     = CNT_W'(T_AMBER - 1);
    localparam logic [CNT_W-1:0] R_ALLRED    = CNT_W'(T_ALLRED - 1);
    localparam logic [AW-1:0]    LAST_APP    = AW'(N_APP - 1);

    state_e           state_q,     state_d;
    logic [AW-1:0]    cur_app_q,   cur_app_d;
    logic [CNT_W-1:0] remain_q,    remain_d;
    logic [N_APP-1:0] ped_lat_q,   ped_lat_d;
    logic             walk_flag_q, walk_flag_d;
    logic             flash_ph_q,  flash_ph_d;
    // Set after reset or FLASH so the next ALL_RED hands green to approach 0
    // instead of advancing the rotation.
    logic             first_q,     first_d;

    logic [AW-1:0]    next_app;
    logic             next_walk;

    // Approach that the next GREEN will serve, and whether it has a pending walk.
    assign next_app  = (first_q || cur_app_q == LAST_APP) ? '0 : cur_app_q + 1'b1;
    assign next_walk = ped_lat_q[next_app] | ped_req[next_app];

    // Next-state, counter, pedestrian latch and flash-phase logic.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        cur_app_d   = cur_app_q;
        remain_d    = remain_q;
        walk_flag_d = walk_flag_q;
        flash_ph_d  = flash_ph_q;
        first_d     = first_q;
        ped_lat_d   = ped_lat_q | ped_req;

        if (tick) begin
            unique case (state_q)
                S_ALL_RED: begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - 1'b1;
                    end else if (flash_mode) begin
                        state_d  = S_FLASH;
                        remain_d = '0;
                    end else begin
                        state_d              = S_GREEN;
                        cur_app_d            = next_app;
                        first_d              = 1'b0;
                        walk_flag_d          = next_walk;
                        // A request arriving on this very cycle is absorbed into the walk.
                        ped_lat_d[next_app]  = 1'b0;
                        remain_d             = next_walk ? R_GREEN_PED : R_GREEN;
                    end
                end
                S_GREEN: begin
                    if (flash_mode || remain_q == '0) begin
                        state_d  = S_AMBER;
                        remain_d = R_AMBER;
                    end else begin
                        remain_d = remain_q - 1'b1;
                    end
                end
                S_AMBER: begin
                    if (remain_q == '0) begin
                        state_d  = S_ALL_RED;
                        remain_d = R_ALLRED;
                    end else begin
                        remain_d = remain_q - 1'b1;
                    end
                end
                S_FLASH: begin
                    flash_ph_d = ~flash_ph_q;
                    if (!flash_mode) begin
                        state_d   = S_ALL_RED;
                        remain_d  = R_ALLRED;
                        cur_app_d = '0;
                        first_d   = 1'b1;
                    end
                end
                default: state_d = S_ALL_RED;
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q     <= S_ALL_RED;
            cur_app_q   <= '0;
            remain_q    <= R_ALLRED;
            ped_lat_q   <= '0;
            walk_flag_q <= 1'b0;
            flash_ph_q  <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_app_q   <= cur_app_d;
            remain_q    <= remain_d;
            ped_lat_q   <= ped_lat_d;
            walk_flag_q <= walk_flag_d;
            flash_ph_q  <= flash_ph_d;
            first_q     <= first_d;
        end
    end

    // Moore lamp decode from the registered state.
    always_comb begin
        red_o   = '1;
        amber_o = '0;
        green_o = '0;
        walk_o  = '0;
        unique case (state_q)
            S_GREEN: begin
                red_o[cur_app_q]   = 1'b0;
                green_o[cur_app_q] = 1'b1;
                walk_o[cur_app_q]  = walk_flag_q;
            end
            S_AMBER: begin
                red_o[cur_app_q]   = 1'b0;
                amber_o[cur_app_q] = 1'b1;
            end
            S_FLASH: begin
                red_o   = '0;
                amber_o = {N_APP{flash_ph_q}};
            end
            default: ;
        endcase
    end

    assign cur_app = cur_app_q;
    assign remain  = remain_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed testbench for traffic_phase_ctrl with the default parameters
// (N_APP=4, T_GREEN=25, T_AMBER=5, T_ALLRED=2, T_PED=10).
module tb_traffic_phase_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] ped_req;
    logic       flash_mode;
    logic [3:0] red_o, amber_o, green_o, walk_o;
    logic [1:0] cur_app;
    logic [7:0] remain;

    int n_tests = 0;
    int n_fail  = 0;

    traffic_phase_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .red_o      (red_o),
        .amber_o    (amber_o),
        .green_o    (green_o),
        .walk_o     (walk_o),
        .cur_app    (cur_app),
        .remain     (remain)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lamp invariants, evaluated on every cycle.
    task automatic check_inv();
        int          n_on;
        logic        excl_ok;
        logic [3:0]  ga;
        ga      = green_o | amber_o;
        n_on    = 0;
        excl_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ga[i]) n_on++;
            if ((32'(red_o[i]) + 32'(amber_o[i]) + 32'(green_o[i])) != 1) excl_ok = 1'b0;
        end
        if (red_o == 4'b0000) begin
            check("inv_flash_green_walk", {green_o, walk_o}, 8'h00);
        end else begin
            check("inv_onehot_ga", 32'(n_on <= 1), 1);
            check("inv_exclusive", 32'(excl_ok), 1);
            check("inv_walk_only_green", 32'(walk_o & ~green_o), 0);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic adv();
        @(posedge clk);
        #1;
        check_inv();
    endtask

    // Check lamps for n consecutive cycles, advancing after each check.
    task automatic hold(input string tag, input logic [3:0] r, input logic [3:0] a,
                        input logic [3:0] g, input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {red_o, amber_o, green_o, walk_o}, {r, a, g, w});
            adv();
        end
    endtask

    // Serve one approach through GREEN and AMBER.
    task automatic serve_ga(input int app, input bit walk);
        logic [3:0] m;
        m = 4'b0001 << app;
        check($sformatf("green_entry_app%0d", app), 32'(cur_app), app);
        check($sformatf("green_entry_remain%0d", app), 32'(remain), walk ? 34 : 24);
        hold($sformatf("green_app%0d", app), ~m, 4'b0000, m, walk ? m : 4'b0000, walk ? 35 : 25);
        hold($sformatf("amber_app%0d", app), ~m, m, 4'b0000, 4'b0000, 5);
    endtask

    task automatic serve(input int app, input bit walk);
        serve_ga(app, walk);
        hold("all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
    endtask

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        ped_req    = 4'b0000;
        flash_mode = 1'b0;
        adv();
        adv();

        // Reset state
        check("reset_lamps", {red_o, amber_o, green_o, walk_o}, 16'hf000);
        check("reset_cur_app", 32'(cur_app), 0);
        check("reset_remain", 32'(remain), 1);

        // Test 1: first cycle after reset, tick every clk
        rst  = 1'b0;
        tick = 1'b1;
        hold("t1_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        check("t1_remain_dec", 32'(remain), 0);
        hold("t1_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        serve(0, 1'b0);
        check("t1_second_green", 32'(green_o), 4'b0010);

        // Test 2: complete the rotation back to approach 0
        serve(1, 1'b0);
        serve(2, 1'b0);
        serve(3, 1'b0);
        check("t2_rotation_app", 32'(cur_app), 0);

        // Test 3: ped_req[2] pulsed while approach 0 is green
        check("t3_remain_entry", 32'(remain), 24);
        ped_req = 4'b0100;
        hold("t3_green0", 4'b1110, 4'b0000, 4'b0001, 4'b0000, 1);
        ped_req = 4'b0000;
        hold("t3_green0", 4'b1110, 4'b0000, 4'b0001, 4'b0000, 24);
        hold("t3_amber0", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 5);
        hold("t3_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
        serve(1, 1'b0);
        serve(2, 1'b1);
        serve(3, 1'b0);

        // Test 6: ped_req[1] high on the cycle approach 1 enters GREEN
        serve_ga(0, 1'b0);
        hold("t6_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        ped_req = 4'b0010;
        hold("t6_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        ped_req = 4'b0000;
        serve(1, 1'b1);
        serve(2, 1'b0);      // second service of approach 2: no walk
        serve(3, 1'b0);
        serve(0, 1'b0);
        serve(1, 1'b0);      // latch for approach 1 was consumed

        // Test 4: flash_mode raised at remain=10 in GREEN of approach 2
        check("t4_entry_app", 32'(cur_app), 2);
        hold("t4_green2", 4'b1011, 4'b0000, 4'b0100, 4'b0000, 14);
        check("t4_remain10", 32'(remain), 10);
        flash_mode = 1'b1;
        hold("t4_green2_last", 4'b1011, 4'b0000, 4'b0100, 4'b0000, 1);
        check("t4_amber_remain", 32'(remain), 4);
        hold("t4_amber2", 4'b1011, 4'b0100, 4'b0000, 4'b0000, 5);
        hold("t4_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
        check("t4_flash_remain", 32'(remain), 0);
        for (int i = 0; i < 6; i++) begin
            check("t4_flash", {red_o, amber_o, green_o, walk_o},
                  {4'b0000, (i % 2 == 1) ? 4'b1111 : 4'b0000, 8'h00});
            adv();
        end
        flash_mode = 1'b0;
        check("t4_flash_last", {red_o, amber_o, green_o, walk_o}, 16'h0000);
        adv();
        check("t4_exit_app", 32'(cur_app), 0);
        check("t4_exit_remain", 32'(remain), 1);
        hold("t4_all_red_exit", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);

        // Test 5: tick held low mid-GREEN, then reset mid-AMBER
        check("t5_entry_app", 32'(cur_app), 0);
        check("t5_entry_remain", 32'(remain), 24);
        hold("t5_green0", 4'b1110, 4'b0000, 4'b0001, 4'b0000, 5);
        tick = 1'b0;
        for (int i = 0; i < 100; i++) begin
            adv();
            check("t5_frozen_lamps", {red_o, amber_o, green_o, walk_o}, 16'he010);
            check("t5_frozen_remain", 32'(remain), 19);
        end
        tick = 1'b1;
        hold("t5_green0_resume", 4'b1110, 4'b0000, 4'b0001, 4'b0000, 20);
        hold("t5_amber0", 4'b1110, 4'b0001, 4'b0000, 4'b0000, 2);
        check("t5_amber_remain", 32'(remain), 2);
        rst     = 1'b1;
        ped_req = 4'b0001;
        adv();
        rst     = 1'b0;
        ped_req = 4'b0000;
        check("t5_reset_lamps", {red_o, amber_o, green_o, walk_o}, 16'hf000);
        check("t5_reset_app", 32'(cur_app), 0);
        check("t5_reset_remain", 32'(remain), 1);
        hold("t5_all_red", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);
        serve_ga(0, 1'b0);   // request seen only during reset is dropped

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
